// File: rtl/hls_ctrl_driver.sv
// hls_ctrl_driver: one-job-in-flight host wrapper for an ap_ctrl_hs HLS core.
// Define HLS_DRV_TIMEOUT_EN to compile in the TIMEOUT_CYCLES watchdog.
module hls_ctrl_driver #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        ap_clk,
    input  logic        ap_rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [31:0] cmd_op1,
    input  logic [31:0] cmd_op2,
    input  logic [31:0] cmd_op3,
    input  logic [31:0] cmd_op4,
    input  logic [31:0] cmd_op5,
    input  logic [31:0] cmd_op6,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_o1,
    output logic [31:0] rsp_o2,
    output logic [31:0] rsp_o3,
    output logic [31:0] rsp_o4,
    output logic [3:0]  rsp_vld,
    output logic        rsp_timeout,
    output logic        ap_start,
    input  logic        ap_done,
    input  logic        ap_idle,
    input  logic        ap_ready,
    output logic [31:0] i1,
    output logic [31:0] i2,
    output logic [31:0] i3,
    output logic [31:0] i4,
    output logic [31:0] i5,
    output logic [31:0] i6,
    input  logic [31:0] o1,
    input  logic [31:0] o2,
    input  logic [31:0] o3,
    input  logic [31:0] o4,
    input  logic        o1_ap_vld,
    input  logic        o2_ap_vld,
    input  logic        o3_ap_vld,
    input  logic        o4_ap_vld
);
    typedef enum logic [1:0] {IDLE, START, WAIT, RESP} state_t;
    state_t state_q, state_d;
    logic [5:0][31:0] i_q, i_d;
    logic [3:0][31:0] rsp_o_q, rsp_o_d, o_in;
    logic [3:0] rsp_vld_q, rsp_vld_d, o_vld;
    logic accept, busy, done_ev, tmo;
    logic unused_ok;
    assign unused_ok = ap_idle & (TIMEOUT_CYCLES > 0);
    assign accept = (state_q == IDLE) & cmd_valid;
    assign busy = (state_q == START) | (state_q == WAIT);
    // ap_done only counts once the core has taken the start (ap_ready seen)
    assign done_ev = ap_done & (((state_q == START) & ap_ready) | (state_q == WAIT));
    assign o_in = {o4, o3, o2, o1};
    assign o_vld = {o4_ap_vld, o3_ap_vld, o2_ap_vld, o1_ap_vld};
`ifdef HLS_DRV_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    logic rsp_timeout_q, rsp_timeout_d;
    assign tmo = busy & (cnt_q == CW'(TIMEOUT_CYCLES - 1)) & ~done_ev;
    always_comb begin
        cnt_d = busy ? cnt_q + 1'b1 : '0;
        rsp_timeout_d = accept ? 1'b0 : tmo ? 1'b1 : rsp_timeout_q;
    end
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            cnt_q <= '0;
            rsp_timeout_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end
    assign rsp_timeout = rsp_timeout_q;
`else
    assign tmo = 1'b0;
    assign rsp_timeout = 1'b0;
`endif
    always_comb begin
        state_d = (done_ev | tmo) ? RESP :
                  ((state_q == START) & ap_ready) ? WAIT :
                  accept ? START :
                  ((state_q == RESP) & rsp_ready) ? IDLE : state_q;
        i_d = accept ? {cmd_op6, cmd_op5, cmd_op4, cmd_op3, cmd_op2, cmd_op1} : i_q;
        rsp_o_d = rsp_o_q;
        for (int k = 0; k < 4; k++)
            rsp_o_d[k] = accept ? 32'd0 : (busy & o_vld[k]) ? o_in[k] : rsp_o_q[k];
        rsp_vld_d = accept ? 4'd0 : busy ? (rsp_vld_q | o_vld) : rsp_vld_q;
    end
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            state_q <= IDLE;
            i_q <= '0;
            rsp_o_q <= '0;
            rsp_vld_q <= '0;
        end else begin
            state_q <= state_d;
            i_q <= i_d;
            rsp_o_q <= rsp_o_d;
            rsp_vld_q <= rsp_vld_d;
        end
    end
    assign cmd_ready = state_q == IDLE;
    assign ap_start = state_q == START;
    assign rsp_valid = state_q == RESP;
    assign {i6, i5, i4, i3, i2, i1} = i_q;
    assign {rsp_o4, rsp_o3, rsp_o2, rsp_o1} = rsp_o_q;
    assign rsp_vld = rsp_vld_q;
endmodule

// File: tb/tb_hls_ctrl_driver.sv
// tb_hls_ctrl_driver: directed checks of the handshake driver (watchdog steps
// compile only when HLS_DRV_TIMEOUT_EN is defined).
module tb_hls_ctrl_driver;
    logic ap_clk = 0, ap_rst = 1;
    logic cmd_valid = 0, cmd_ready, rsp_valid, rsp_ready = 0, rsp_timeout, ap_start;
    logic ap_done = 0, ap_idle = 0, ap_ready = 0;
    logic [31:0] cmd_op1 = 0, cmd_op2 = 0, cmd_op3 = 0, cmd_op4 = 0, cmd_op5 = 0, cmd_op6 = 0;
    logic [31:0] rsp_o1, rsp_o2, rsp_o3, rsp_o4, i1, i2, i3, i4, i5, i6;
    logic [31:0] o1 = 0, o2 = 0, o3 = 0, o4 = 0;
    logic o1_ap_vld = 0, o2_ap_vld = 0, o3_ap_vld = 0, o4_ap_vld = 0;
    logic [3:0] rsp_vld;
    int errs = 0, checks = 0;

    always #5 ap_clk = ~ap_clk;

    hls_ctrl_driver #(.TIMEOUT_CYCLES(8)) dut (
        .ap_clk(ap_clk), .ap_rst(ap_rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op1(cmd_op1), .cmd_op2(cmd_op2), .cmd_op3(cmd_op3), .cmd_op4(cmd_op4),
        .cmd_op5(cmd_op5), .cmd_op6(cmd_op6), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_o1(rsp_o1), .rsp_o2(rsp_o2), .rsp_o3(rsp_o3), .rsp_o4(rsp_o4),
        .rsp_vld(rsp_vld), .rsp_timeout(rsp_timeout), .ap_start(ap_start),
        .ap_done(ap_done), .ap_idle(ap_idle), .ap_ready(ap_ready),
        .i1(i1), .i2(i2), .i3(i3), .i4(i4), .i5(i5), .i6(i6),
        .o1(o1), .o2(o2), .o3(o3), .o4(o4),
        .o1_ap_vld(o1_ap_vld), .o2_ap_vld(o2_ap_vld), .o3_ap_vld(o3_ap_vld), .o4_ap_vld(o4_ap_vld)
    );

    task automatic step();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        step();
        step();
        ap_rst = 0;
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_ap_start", ap_start, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_vld", rsp_vld, 0);
        chk("rst_i1", i1, 0);
        chk("rst_rsp_o1", rsp_o1, 0);
        chk("rst_timeout", rsp_timeout, 0);

        // Scenario 1: ready/done three cycles after start, o1 and o3 valid
        {cmd_op1, cmd_op2, cmd_op3, cmd_op4, cmd_op5, cmd_op6} = {32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6};
        cmd_valid = 1;
        step();
        cmd_valid = 0;
        cmd_op1 = 32'h77;
        chk("s1_ap_start", ap_start, 1);
        chk("s1_cmd_ready", cmd_ready, 0);
        chk("s1_i1", i1, 1);
        chk("s1_i6", i6, 6);
        o1 = 32'h10;
        o1_ap_vld = 1;
        step();
        o1_ap_vld = 0;
        chk("s1_i1_hold", i1, 1);
        step();
        chk("s1_start_wait", ap_start, 1);
        ap_ready = 1;
        ap_done = 1;
        o3 = 32'h30;
        o3_ap_vld = 1;
        step();
        {ap_ready, ap_done, o3_ap_vld} = 3'b000;
        chk("s1_rsp_valid", rsp_valid, 1);
        chk("s1_ap_start_off", ap_start, 0);
        chk("s1_rsp_o1", rsp_o1, 32'h10);
        chk("s1_rsp_o2", rsp_o2, 0);
        chk("s1_rsp_o3", rsp_o3, 32'h30);
        chk("s1_rsp_vld", rsp_vld, 4'b0101);
        chk("s1_timeout", rsp_timeout, 0);
        rsp_ready = 1;
        step();
        rsp_ready = 0;
        chk("s1_back_idle", cmd_ready, 1);
        chk("s1_rsp_dropped", rsp_valid, 0);

        // Core status in IDLE must be ignored
        o4 = 32'h44;
        o4_ap_vld = 1;
        ap_done = 1;
        step();
        {o4_ap_vld, ap_done} = 2'b00;
        chk("idle_ignore_vld", rsp_vld, 4'b0101);
        chk("idle_ignore_o4", rsp_o4, 0);
        chk("idle_ignore_state", rsp_valid, 0);

        // Scenario 2: minimum latency
        cmd_valid = 1;
        step();
        cmd_valid = 0;
        chk("s2_start_c1", ap_start, 1);
        ap_ready = 1;
        ap_done = 1;
        step();
        {ap_ready, ap_done} = 2'b00;
        chk("s2_start_1cyc", ap_start, 0);
        chk("s2_rsp_c2", rsp_valid, 1);
        chk("s2_vld_cleared", rsp_vld, 0);
        chk("s2_o1_cleared", rsp_o1, 0);

        // Scenario 3: response back-pressure with a pending command
        cmd_op1 = 32'hABC;
        cmd_valid = 1;
        for (int n = 0; n < 5; n++) begin
            step();
            chk("s3_rsp_hold", rsp_valid, 1);
            chk("s3_cmd_blocked", cmd_ready, 0);
            chk("s3_o1_stable", rsp_o1, 0);
        end
        rsp_ready = 1;
        step();
        rsp_ready = 0;
        chk("s3_idle_after_hs", cmd_ready, 1);
        chk("s3_i1_not_yet", i1, 32'h77);
        step();
        cmd_valid = 0;
        chk("s3_accept_next", ap_start, 1);
        chk("s3_i1_new", i1, 32'hABC);

        // Scenario 6: WAIT path with o2 written twice
        ap_ready = 1;
        step();
        ap_ready = 0;
        chk("s6_wait_no_start", ap_start, 0);
        chk("s6_wait_no_rsp", rsp_valid, 0);
        o2 = 32'hA;
        o2_ap_vld = 1;
        step();
        o2 = 32'hB;
        step();
        o2_ap_vld = 0;
        step();
        chk("s6_wait_persist", rsp_valid, 0);
        ap_done = 1;
        step();
        ap_done = 0;
        chk("s6_rsp_valid", rsp_valid, 1);
        chk("s6_rsp_o2", rsp_o2, 32'hB);
        chk("s6_rsp_vld", rsp_vld, 4'b0010);
        o1 = 32'h99;
        o1_ap_vld = 1;
        step();
        o1_ap_vld = 0;
        chk("resp_ignore_o1", rsp_o1, 0);
        chk("resp_ignore_vld", rsp_vld, 4'b0010);
        rsp_ready = 1;
        step();
        rsp_ready = 0;

        // Scenario 5: reset during WAIT abandons the job
        cmd_valid = 1;
        step();
        cmd_valid = 0;
        ap_ready = 1;
        step();
        ap_ready = 0;
        chk("s5_in_wait", ap_start, 0);
        #2 ap_rst = 1;
        #1;
        chk("s5_rst_ap_start", ap_start, 0);
        chk("s5_rst_rsp_valid", rsp_valid, 0);
        chk("s5_rst_i1", i1, 0);
        chk("s5_rst_cmd_ready", cmd_ready, 1);
        step();
        ap_rst = 0;
        ap_done = 1;
        step();
        ap_done = 0;
        chk("s5_no_response", rsp_valid, 0);
        cmd_valid = 1;
        step();
        cmd_valid = 0;
        chk("s5_start_again", ap_start, 1);
        #2 ap_rst = 1;
        #1;
        chk("s5_async_start_drop", ap_start, 0);
        step();
        ap_rst = 0;
        cmd_op2 = 32'h22;
        cmd_valid = 1;
        step();
        cmd_valid = 0;
        chk("s5_next_start", ap_start, 1);
        chk("s5_next_i2", i2, 32'h22);
        ap_ready = 1;
        ap_done = 1;
        step();
        {ap_ready, ap_done} = 2'b00;
        chk("s5_next_rsp", rsp_valid, 1);
        chk("s5_next_timeout", rsp_timeout, 0);
        rsp_ready = 1;
        step();
        rsp_ready = 0;
        chk("s5_next_idle", cmd_ready, 1);

`ifdef HLS_DRV_TIMEOUT_EN
        // Scenario 4: watchdog with TIMEOUT_CYCLES=8 and no ap_done
        cmd_valid = 1;
        step();
        cmd_valid = 0;
        o4 = 32'h4;
        o4_ap_vld = 1;
        for (int n = 1; n < 8; n++) begin
            chk("s4_no_rsp_yet", rsp_valid, 0);
            if (n == 3) ap_ready = 1;
            step();
            {o4_ap_vld, ap_ready} = 2'b00;
        end
        chk("s4_no_rsp_c7", rsp_valid, 0);
        step();
        chk("s4_rsp_c8", rsp_valid, 1);
        chk("s4_timeout", rsp_timeout, 1);
        chk("s4_ap_start", ap_start, 0);
        chk("s4_vld_kept", rsp_vld, 4'b1000);
        rsp_ready = 1;
        step();
        rsp_ready = 0;
        cmd_valid = 1;
        step();
        cmd_valid = 0;
        chk("s4_timeout_cleared", rsp_timeout, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/hls_ctrl_driver.md
HLS_CTRL_DRIVER -- requirements
Module: hls_ctrl_driver

Interface
REQ-001 The block SHALL have one parameter, TIMEOUT_CYCLES, default 1024, the watchdog limit in cycles counted from ap_start assertion to ap_done.
REQ-002 ap_clk  input  1  single clock; all state SHALL be updated on its rising edge.
REQ-003 ap_rst  input  1  asynchronous, active-high reset.
REQ-004 cmd_valid  input  1  host presents an operand set.
REQ-005 cmd_ready  output  1  driver accepts an operand set.
REQ-006 cmd_op1..cmd_op6  input  32 each  operands destined for core i1..i6.
REQ-007 rsp_valid  output  1  result record available.
REQ-008 rsp_ready  input  1  host consumes the result record.
REQ-009 rsp_o1..rsp_o4  output  32 each  captured core results.
REQ-010 rsp_vld  output  4  sticky mask; bit k-1 set if ok_ap_vld was seen during the job.
REQ-011 rsp_timeout  output  1  job ended by watchdog, not by ap_done.
REQ-012 ap_start  output  1  core start request (ap_ctrl_hs).
REQ-013 ap_done, ap_idle, ap_ready  input  1 each  core status.
REQ-014 i1..i6  output  32 each  core operands.
REQ-015 o1..o4  input  32 each  core results; o1_ap_vld..o4_ap_vld  input  1 each  result qualifiers.

Function
REQ-016 FSM states SHALL be IDLE, START, WAIT, RESP.
REQ-017 In IDLE, cmd_ready SHALL be 1; cmd_valid&cmd_ready SHALL latch cmd_op1..6 into i1..i6, clear rsp_vld, rsp_o1..4 and rsp_timeout, and move to START.
REQ-018 In START, ap_start SHALL be 1, and the FSM SHALL stay in START until ap_ready is sampled 1, then move to WAIT; if ap_done is also 1 in that cycle, it SHALL move directly to RESP.
REQ-019 In WAIT, ap_start SHALL be 0; ap_done=1 SHALL move the FSM to RESP.
REQ-020 i1..i6 SHALL be held stable from leaving IDLE until RESP is entered.
REQ-021 In START and WAIT, any cycle with ok_ap_vld=1 SHALL register ok into rsp_ok and set rsp_vld[k-1]; the last write wins; a vld in the ap_done cycle SHALL be captured.
REQ-022 In RESP, rsp_valid SHALL be 1 and all rsp_* outputs SHALL be stable; rsp_valid&rsp_ready SHALL return the FSM to IDLE.
REQ-023 cmd_ready SHALL be 0 outside IDLE, giving one job in flight; a new command SHALL be accepted no earlier than the cycle after the response handshake.
REQ-024 ap_done or ok_ap_vld arriving in IDLE or RESP SHALL be ignored.
REQ-025 ap_idle SHALL be observed only; it SHALL NOT affect state.
REQ-026 Minimum latency, with ap_ready and ap_done high in the first START cycle, SHALL be cmd accept at cycle 0, ap_start at cycle 1, and rsp_valid at cycle 2.

Reset
REQ-027 ap_rst=1 SHALL immediately force IDLE, ap_start=0, cmd_ready=1 (once released), rsp_valid=0, rsp_timeout=0, rsp_vld=0, and rsp_o1..4, i1..i6 and the watchdog counter to 0.
REQ-028 Reset mid-job SHALL abandon the job with no response; ap_start SHALL drop asynchronously.

Configuration
REQ-029 Macro HLS_DRV_TIMEOUT_EN SHALL compile in a watchdog counter that starts at 0 on entry to START and increments each START/WAIT cycle.
REQ-030 When the count reaches TIMEOUT_CYCLES-1 without ap_done, the FSM SHALL enter RESP with rsp_timeout=1, ap_start=0, and the captured values and mask as collected so far.
REQ-031 Without HLS_DRV_TIMEOUT_EN, the counter SHALL be absent, rsp_timeout SHALL be tied 0, and WAIT/START SHALL persist indefinitely.

Verification
REQ-032 Scenario 1: cmd ops 1..6 with ap_ready/ap_done 3 cycles later and o1=0x10 (vld), o3=0x30 (vld) -> rsp_o1=0x10, rsp_o3=0x30, rsp_vld=4'b0101, rsp_timeout=0.
REQ-033 Scenario 2: ap_ready and ap_done in the same cycle as the first ap_start -> ap_start high exactly 1 cycle and rsp_valid the next cycle.
REQ-034 Scenario 3: rsp_ready held 0 for 5 cycles with cmd_valid=1 -> rsp_* stable, cmd_ready=0 throughout, and accept occurs the cycle after rsp_ready=1.
REQ-035 Scenario 4: with the macro defined, TIMEOUT_CYCLES=8, and ap_done never asserted -> rsp_valid 8 cycles after START entry with rsp_timeout=1 and ap_start=0.
REQ-036 Scenario 5: ap_rst pulsed during WAIT -> ap_start and rsp_valid 0 in the same cycle, no response is issued, and the next command completes normally.
REQ-037 Scenario 6: o2_ap_vld pulsed twice with 0xA then 0xB -> rsp_o2=0xB and rsp_vld[1]=1.
